// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared core types and constants: load/store size codes,
//               MEM control bit layout and the LSU state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Load/store size codes carried in mem_ctrl[4:2]
    typedef enum logic [2:0] {
        LDST_B  = 3'b000,
        LDST_H  = 3'b001,
        LDST_W  = 3'b010,
        LDST_BU = 3'b100,
        LDST_HU = 3'b101
    } ldst_e;

    // MEM control bundle layout
    localparam int MEM_CTRL_W   = 5;
    localparam int MEMREAD_BIT  = 0;
    localparam int MEMWRITE_BIT = 1;
    localparam int LDST_LSB     = 2;

    // LSU access state
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_e;

    // log2 of the access size in bytes; unknown codes behave as a word
    function automatic logic [1:0] ldst_size_log2(input logic [2:0] ldst);
        logic [1:0] size;
        case (ldst)
            LDST_B, LDST_BU: size = 2'd0;
            LDST_H, LDST_HU: size = 2'd1;
            default:         size = 2'd2;
        endcase
        return size;
    endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane alignment for data-memory accesses.
//               Produces byte enables and lane-replicated store data, and
//               selects/extends the addressed lane of a read word.
//               The low offset bits are truncated to the natural alignment
//               of the access size.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import core_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [2:0]          i_ldst,
    input  logic [OFF_W-1:0]    i_off,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W-1:0]   i_rdata,
    output logic [DATA_W/8-1:0] o_be,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W-1:0]   o_rdata
);

    localparam int c_NB = DATA_W / 8;

    logic [1:0]        w_size;
    logic [OFF_W-1:0]  w_off_al;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_word_ext;

    // Size decode and offset truncated to the natural alignment
    always_comb begin
        w_size   = ldst_size_log2(i_ldst);
        w_off_al = i_off;
        case (w_size)
            2'd1:    w_off_al[0]   = 1'b0;
            2'd2:    w_off_al[1:0] = 2'b00;
            default: ;
        endcase
    end

    // Byte enables: a 1/2/4-byte group starting at the aligned offset
    always_comb begin
        case (w_size)
            2'd0:    o_be = c_NB'(1)     << w_off_al;
            2'd1:    o_be = c_NB'(2'b11) << w_off_al;
            default: o_be = c_NB'(4'hF)  << w_off_al;
        endcase
    end

    // Store data: the source unit is repeated across every lane
    always_comb begin
        o_wdata = '0;
        for (int i = 0; i < c_NB; i++) begin
            case (w_size)
                2'd0:    o_wdata[i*8 +: 8] = i_wdata[7:0];
                2'd1:    o_wdata[i*8 +: 8] = i_wdata[(i % 2)*8 +: 8];
                default: o_wdata[i*8 +: 8] = i_wdata[(i % 4)*8 +: 8];
            endcase
        end
    end

    assign w_shift = i_rdata >> {w_off_al, 3'b000};

    // A word on a wider datapath is sign-extended like a byte or half
    generate
        if (DATA_W > 32) begin : g_wide_word
            assign w_word_ext = {{(DATA_W-32){w_shift[31]}}, w_shift[31:0]};
        end else begin : g_native_word
            assign w_word_ext = w_shift;
        end
    endgenerate

    // Load formatting: pick the lane, then sign- or zero-extend
    always_comb begin
        case (i_ldst)
            LDST_B:  o_rdata = {{(DATA_W-8){w_shift[7]}},   w_shift[7:0]};
            LDST_BU: o_rdata = {{(DATA_W-8){1'b0}},         w_shift[7:0]};
            LDST_H:  o_rdata = {{(DATA_W-16){w_shift[15]}}, w_shift[15:0]};
            LDST_HU: o_rdata = {{(DATA_W-16){1'b0}},        w_shift[15:0]};
            default: o_rdata = w_word_ext;
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/stage_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : stage_mem_lsu
// Description : MEM pipeline stage with a variable-latency req/ack data port.
//               Launches one access per memory instruction, stalls upstream
//               until mem_ack (or timeout abort), then registers the result
//               for WB. Non-memory instructions pass through in one cycle.
//               Optional macro MEM_MISALIGN_TRAP_EN adds a 'misalign' output
//               and suppresses misaligned halfword/word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_mem_lsu
    import core_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REGS_W    = 5,
    parameter int WB_CTRL_W = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [MEM_CTRL_W-1:0] mem_ctrl_in,
    input  logic [WB_CTRL_W-1:0]  wb_ctrl_in,
    input  logic [REGS_W-1:0]     rd_in,
    input  logic [DATA_W-1:0]     addr_in,
    input  logic [DATA_W-1:0]     wdata_in,
    output logic                  stall_out,
    output logic                  valid_out,
    output logic [WB_CTRL_W-1:0]  wb_ctrl_out,
    output logic [REGS_W-1:0]     rd_out,
    output logic [DATA_W-1:0]     addr_out,
    output logic [DATA_W-1:0]     data_out,
    output logic                  bus_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign
`endif
);

    localparam int c_NB    = DATA_W / 8;
    localparam int c_OFF_W = $clog2(c_NB);
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_e          r_state;
    lsu_state_e          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_memread;
    logic                w_memwrite;
    logic                w_memop;
    logic [2:0]          w_ldst_in;
    logic                w_misal;
    logic                w_timeout;
    logic                w_launch;
    logic                w_complete;
    logic                w_abort;
    logic                w_stall;

    // Instruction held while the access is outstanding
    logic [2:0]          r_ldst;
    logic [c_OFF_W-1:0]  r_off;
    logic                r_is_load;
    logic [WB_CTRL_W-1:0] r_p_wb;
    logic [REGS_W-1:0]   r_p_rd;
    logic [DATA_W-1:0]   r_p_addr;

    logic [2:0]          w_al_ldst;
    logic [c_OFF_W-1:0]  w_al_off;
    logic [c_NB-1:0]     w_be;
    logic [DATA_W-1:0]   w_wdata_lane;
    logic [DATA_W-1:0]   w_rdata_fmt;

    assign w_memread  = valid_in & mem_ctrl_in[MEMREAD_BIT];
    assign w_memwrite = valid_in & mem_ctrl_in[MEMWRITE_BIT];
    assign w_memop    = w_memread | w_memwrite;
    assign w_ldst_in  = mem_ctrl_in[LDST_LSB +: 3];

`ifdef MEM_MISALIGN_TRAP_EN
    // Halfword at an odd address, or word not on a 4-byte boundary
    always_comb begin
        w_misal = 1'b0;
        if (w_memop) begin
            case (ldst_size_log2(w_ldst_in))
                2'd1:    w_misal = addr_in[0];
                2'd2:    w_misal = |addr_in[1:0];
                default: w_misal = 1'b0;
            endcase
        end
    end
`else
    assign w_misal = 1'b0;
`endif

    // Abort fires in the BUSY cycle where the wait count reaches TIMEOUT
    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // The aligner sees the incoming op in IDLE and the held op in BUSY
    assign w_al_ldst = (r_state == BUSY) ? r_ldst : w_ldst_in;
    assign w_al_off  = (r_state == BUSY) ? r_off  : addr_in[c_OFF_W-1:0];

    lsu_align #(
        .DATA_W (DATA_W),
        .OFF_W  (c_OFF_W)
    ) u_align (
        .i_ldst  (w_al_ldst),
        .i_off   (w_al_off),
        .i_wdata (wdata_in),
        .i_rdata (mem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata_lane),
        .o_rdata (w_rdata_fmt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: launch on a memory op, leave BUSY on ack or abort
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_launch) w_state_nxt = BUSY;
            BUSY:    if (mem_ack || w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: stall is released in the ack or abort cycle only
    always_comb begin
        w_launch   = 1'b0;
        w_complete = 1'b0;
        w_abort    = 1'b0;
        w_stall    = 1'b0;
        case (r_state)
            IDLE: begin
                w_launch = w_memop & ~w_misal;
                w_stall  = w_launch;
            end
            BUSY: begin
                w_complete = mem_ack;
                w_abort    = ~mem_ack & w_timeout;
                w_stall    = ~mem_ack & ~w_timeout;
            end
            default: ;
        endcase
    end

    // Upstream must never see a stall while the stage is held in reset
    assign stall_out = w_stall & rst_n;

    // Wait counter: cleared at launch, counts every BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_cnt <= '0;
        else if (w_launch)         r_cnt <= '0;
        else if (r_state == BUSY)  r_cnt <= r_cnt + c_CNT_W'(1);
    end

    // Memory port: captured at launch, held until ack or abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else if (w_launch) begin
            mem_req   <= 1'b1;
            mem_we    <= w_memwrite;
            mem_addr  <= {addr_in[DATA_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
            mem_be    <= w_be;
            mem_wdata <= w_wdata_lane;
        end else if (w_complete || w_abort) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    // Pending instruction fields, consumed when the access completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ldst    <= '0;
            r_off     <= '0;
            r_is_load <= 1'b0;
            r_p_wb    <= '0;
            r_p_rd    <= '0;
            r_p_addr  <= '0;
        end else if (w_launch) begin
            r_ldst    <= w_ldst_in;
            r_off     <= addr_in[c_OFF_W-1:0];
            r_is_load <= w_memread & ~w_memwrite;
            r_p_wb    <= wb_ctrl_in;
            r_p_rd    <= rd_in;
            r_p_addr  <= addr_in;
        end
    end

    // WB output registers and the bus-error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out   <= 1'b0;
            wb_ctrl_out <= '0;
            rd_out      <= '0;
            addr_out    <= '0;
            data_out    <= '0;
            bus_err     <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            bus_err   <= 1'b0;
            if (r_state == IDLE) begin
                if (valid_in && !w_memop) begin
                    valid_out   <= 1'b1;
                    wb_ctrl_out <= wb_ctrl_in;
                    rd_out      <= rd_in;
                    addr_out    <= addr_in;
                    data_out    <= '0;
                end
            end else if (w_complete) begin
                valid_out   <= 1'b1;
                wb_ctrl_out <= r_p_wb;
                rd_out      <= r_p_rd;
                addr_out    <= r_p_addr;
                data_out    <= r_is_load ? w_rdata_fmt : '0;
            end else if (w_abort) begin
                bus_err <= 1'b1;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // One-cycle trap pulse; the instruction is dropped without a request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign <= 1'b0;
        else        misalign <= (r_state == IDLE) & w_misal;
    end
`endif

endmodule : stage_mem_lsu
`default_nettype wire

// File: doc/stage_mem_lsu.md
Name: stage_mem_lsu

Overview:
- Parametrised successor to the single-cycle MEM stage.
- Drives a request/acknowledge data-memory port with variable latency.
- Generates byte enables and aligned store data, and aligns and sign/zero-extends load data.
- Stalls the pipeline while an access is outstanding, then presents registered results to WB. Sits between the EX/MEM register and the WB stage.

Parameters:
- DATA_W, 32, data/address width; multiple of 8, minimum 32.
- REGS_W, 5, destination register index width.
- WB_CTRL_W, 2, WB control bundle width.
- TIMEOUT, 255, maximum wait cycles for mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  EX/MEM slot holds a real instruction
- mem_ctrl_in  in  5  [0] MemRead, [1] MemWrite, [4:2] LDST
- wb_ctrl_in  in  WB_CTRL_W  WB control, passed through
- rd_in  in  REGS_W  destination register
- addr_in  in  DATA_W  ALU result / effective address
- wdata_in  in  DATA_W  store source (rs2)
- stall_out  out  1  freeze upstream stages and hold EX/MEM inputs
- valid_out  out  1  WB slot valid
- wb_ctrl_out  out  WB_CTRL_W  registered
- rd_out  out  REGS_W  registered
- addr_out  out  DATA_W  registered ALU result
- data_out  out  DATA_W  registered formatted load data
- bus_err  out  1  one-cycle pulse on timeout abort
- mem_req  out  1  access request
- mem_we  out  1  1 = store
- mem_addr  out  DATA_W  word-aligned address (low log2(DATA_W/8) bits zero)
- mem_be  out  DATA_W/8  byte enables
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  DATA_W  read word, valid with mem_ack

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; valid_out, mem_req, mem_we, bus_err, stall_out = 0; all data outputs = 0.
- LDST codes: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only. Other codes are treated as W.
- FSM IDLE:
  - valid_in with neither MemRead nor MemWrite: output registers load on the next edge, valid_out=1. Latency 1, no stall.
  - valid_in with MemRead or MemWrite: stall_out=1 combinationally in the same cycle. Go to BUSY; mem_req, mem_we, mem_addr, mem_be, mem_wdata are registered from the inputs.
  - valid_in=0: valid_out=0 on the next edge.
- FSM BUSY:
  - mem_req=1 and all memory outputs held stable until mem_ack.
  - stall_out=1 except in the cycle mem_ack=1, so upstream advances exactly once.
  - On mem_ack: mem_req drops on the next edge, the output registers load (loads take formatted mem_rdata; stores take data_out=0), valid_out=1, return to IDLE.
  - mem_ack=1 in the same cycle as the request launch is legal: minimum load/store latency is 2 cycles from valid_in.
- Byte enables (off = addr_in low bits):
  - B: 1 << off.
  - H: 2'b11 << off[..1], using off with bit 0 cleared.
  - W: all ones for DATA_W=32. For wider DATA_W, a 4-byte group at off[..2].
- Store data: the source byte/half/word is replicated across the lanes, so every enabled lane carries the correct value.
- Loads: select the lane by off, sign-extend for B/H, zero-extend for BU/HU.
- Timeout: a counter clears on entering BUSY and increments each BUSY cycle. When it reaches TIMEOUT without mem_ack:
  - mem_req drops, bus_err pulses for one cycle, valid_out=0, return to IDLE.
  - stall_out drops for one cycle, so the faulting instruction is dropped.
- mem_ack in IDLE is ignored.
- Reset asserted mid-BUSY: immediate return to IDLE, request withdrawn with no handshake.
- valid_in=0 never raises mem_req, regardless of mem_ctrl_in.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - Adds output port misalign (1 bit).
  - H at odd address, or W with off[1:0]!=0: no memory request is issued.
  - valid_out=0, misalign pulses for one cycle on the next edge, no stall.
- MEM_MISALIGN_TRAP_EN undefined: the port is absent and the low address bits are truncated to the natural alignment (H ignores bit 0, W ignores bits [1:0]).

Decomposition:
- Shared package core_pkg holds:
  - ldst_e enum: LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU.
  - MEM_CTRL_W=5 and the bit indices MEMREAD_BIT=0, MEMWRITE_BIT=1, LDST_LSB=2.
  - lsu_state_e: IDLE, BUSY.
- One natural sub-module: lsu_align (combinational). Generates byte enables and store lane data, and formats load data. It is reused by a future cache.

Test Plan:
- ALU-only op (valid_in=1, ctrl=0, addr 0x1234, rd=5) -> next cycle valid_out=1, addr_out=0x1234, rd_out=5, stall_out never 1, mem_req never 1.
- LB at 0x103, mem_ack after 3 cycles with rdata 0x80FF_0000 -> mem_addr=0x100, mem_be=4'b1000, stall high 3 cycles, data_out=0xFFFF_FF80; LBU gives 0x0000_0080.
- SH at 0x202, wdata 0xAAAA_BEEF -> mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEF_BEEF, valid_out=1 after ack, data_out=0.
- LW with mem_ack in the launch cycle, back-to-back with a second LW -> each completes in 2 cycles, data_out sequence is correct, no dropped or duplicated valid_out.
- TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, bus_err one pulse, valid_out=0, stall released.
- rst_n low mid-BUSY -> mem_req, stall_out, valid_out 0 immediately (async); with MEM_MISALIGN_TRAP_EN, LW at 0x2 -> misalign pulse, no mem_req.
